hd44780_fifo: RTL and testbench
===============================

HD44780_FIFO -- requirements
Module: hd44780_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning entry width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4, meaning log2 of depth (DEPTH = 1<<ADDR_WIDTH = 16).
REQ-003 The block SHALL have parameter AFULL_LEVEL, default 12, meaning almost_full asserts when count >= AFULL_LEVEL.
REQ-004 The block SHALL have parameter AEMPTY_LEVEL, default 2, meaning almost_empty asserts when count <= AEMPTY_LEVEL.
REQ-005 The block SHALL have one clock; reset is synchronous and active-low.
REQ-006 clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  synchronous active-low reset.
REQ-008 clear  input  1  synchronous flush, active-high.
REQ-009 push  input  1  write request.
REQ-010 din  input  DATA_WIDTH  write data, sampled with push.
REQ-011 pop  input  1  read request.
REQ-012 dout  output  DATA_WIDTH  registered read data.
REQ-013 dout_valid  output  1  one-cycle pulse: dout holds newly popped entry.
REQ-014 full, empty, almost_full, almost_empty  output  1 each  level flags.
REQ-015 count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-016 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 A push SHALL be accepted iff push=1 and full=0; accepted data written at wr_ptr, wr_ptr increments modulo DEPTH.
REQ-018 A pop SHALL be accepted iff pop=1 and empty=0; entry at rd_ptr read, rd_ptr increments modulo DEPTH.
REQ-019 Read latency SHALL be 1 cycle: dout and dout_valid=1 appear the cycle after an accepted pop; dout holds its value otherwise; dout_valid=0 in all other cycles.
REQ-020 Simultaneous accepted push and pop SHALL leave count unchanged.
REQ-021 Push while full SHALL be dropped (even if pop=1 same cycle) and set overflow.
REQ-022 Pop while empty SHALL be ignored (even if push=1 same cycle) and set underflow; dout_valid stays 0.
REQ-023 count SHALL be +1 on push-only, -1 on pop-only, unchanged otherwise; full = (count==DEPTH), empty = (count==0), both combinational from registered count.
REQ-024 almost_full and almost_empty SHALL be combinational comparisons of count against AFULL_LEVEL and AEMPTY_LEVEL.
REQ-025 Pointers SHALL be ADDR_WIDTH bits and wrap DEPTH-1 -> 0 without gaps.
REQ-026 overflow and underflow SHALL remain set until rst_n=0 or clear=1.
REQ-027 clear=1 SHALL on the next edge zero pointers, count, overflow, underflow, dout_valid; it overrides push and pop in that cycle; dout and memory contents retained.
REQ-028 Stored entries SHALL be returned in write order with no duplication or loss.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force wr_ptr=0, rd_ptr=0, count=0, dout=0, dout_valid=0, overflow=0, underflow=0; reset overrides clear, push, pop.
REQ-030 After reset: empty=1, full=0, almost_empty=1, almost_full=0.
REQ-031 Reset mid-operation SHALL discard all queued entries; memory array not cleared.

Structure
REQ-032 Default widths, depth and threshold constants SHALL reside in shared package hd44780_pkg.
REQ-033 Storage SHALL be one instance of hd44780_ram (addr_width=ADDR_WIDTH, data_width=DATA_WIDTH, wclk=rclk=clk, write_en=accepted push, raddr=rd_ptr); control logic in hd44780_fifo.
REQ-034 The storage SHALL map to inferred block RAM; no per-entry flip-flops.

Verification
REQ-035 Reset, then push 0x11,0x22,0x33 over three cycles -> count=3, empty=0; three pops -> dout 0x11,0x22,0x33, each with dout_valid one cycle after its pop.
REQ-036 Push 16 entries 0x00..0x0F -> full=1, almost_full=1 from count 12; 17th push 0xAA -> dropped, overflow=1, count stays 16.
REQ-037 Full FIFO, push=pop=1 same cycle -> pop accepted, push dropped, count=15, overflow=1.
REQ-038 Empty FIFO, pop=1 -> underflow=1, dout_valid=0; push=pop=1 next cycle -> count=1, no dout_valid.
REQ-039 Half-full FIFO, continuous push/pop for 40 cycles -> count constant, pointers wrap, data order preserved.
REQ-040 count=5 with overflow=1, assert clear (or rst_n=0) with push=1 -> count=0, empty=1, overflow=0, push ignored.

Source files
------------

// File: rtl/hd44780_pkg.sv
// Shared defaults for the HD44780 command/data FIFO: widths, depth and level thresholds.
package hd44780_pkg;

    localparam int DATA_WIDTH_DEF   = 8;
    localparam int ADDR_WIDTH_DEF   = 4;
    localparam int AFULL_LEVEL_DEF  = 12;
    localparam int AEMPTY_LEVEL_DEF = 2;

    // Number of entries addressed by a pointer of the given width.
    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/hd44780_ram.sv
// Simple dual-port storage for the FIFO. The read port is registered and has no
// reset, so the array maps onto an inferred block RAM.
module hd44780_ram #(
    parameter int addr_width = 4,
    parameter int data_width = 8
) (
    input  logic                  wclk,
    input  logic                  write_en,
    input  logic [addr_width-1:0] waddr,
    input  logic [data_width-1:0] wdata,
    input  logic                  rclk,
    input  logic [addr_width-1:0] raddr,
    output logic [data_width-1:0] rdata
);

    logic [data_width-1:0] mem [0:(1<<addr_width)-1];

    // Write port: store wdata when the controller accepts a push.
    always_ff @(posedge wclk) begin
        if (write_en) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: continuously register the entry at the read pointer.
    always_ff @(posedge rclk) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/hd44780_fifo.sv
// Synchronous FIFO controller for the HD44780 interface: pointers, occupancy,
// level flags and sticky error flags around a block-RAM storage instance.
module hd44780_fifo
    import hd44780_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int AFULL_LEVEL  = AFULL_LEVEL_DEF,
    parameter int AEMPTY_LEVEL = AEMPTY_LEVEL_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                DEPTH      = fifo_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AFULL_CNT  = (ADDR_WIDTH+1)'(AFULL_LEVEL);
    localparam logic [ADDR_WIDTH:0]   AEMPTY_CNT = (ADDR_WIDTH+1)'(AEMPTY_LEVEL);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [DATA_WIDTH-1:0] dout_hold;
    logic                  push_ok;
    logic                  pop_ok;
    logic                  ram_we;

    assign full         = (count == DEPTH_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AFULL_CNT);
    assign almost_empty = (count <= AEMPTY_CNT);

    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Reset and clear both suppress the write so a dropped push never lands in memory.
    assign ram_we = push_ok & ~clear & rst_n;

    // The RAM read port registers mem[rd_ptr] on the pop edge, so the popped entry is
    // on ram_rdata exactly in the dout_valid cycle; afterwards dout_hold keeps it.
    assign dout = dout_valid ? ram_rdata : dout_hold;

    hd44780_ram #(
        .addr_width (ADDR_WIDTH),
        .data_width (DATA_WIDTH)
    ) u_ram (
        .wclk     (clk),
        .write_en (ram_we),
        .waddr    (wr_ptr),
        .wdata    (din),
        .rclk     (clk),
        .raddr    (rd_ptr),
        .rdata    (ram_rdata)
    );

    // Pointer, occupancy, read-valid and sticky error-flag updates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            dout_valid <= 1'b0;
            dout_hold  <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (dout_valid) begin
                dout_hold <= ram_rdata;
            end
            if (clear) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count      <= '0;
                dout_valid <= 1'b0;
                overflow   <= 1'b0;
                underflow  <= 1'b0;
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (pop_ok) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                case ({push_ok, pop_ok})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
                dout_valid <= pop_ok;
                if (push && full) begin
                    overflow <= 1'b1;
                end
                if (pop && empty) begin
                    underflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hd44780_fifo.sv
// Self-checking bench for hd44780_fifo: a queue-based model checked every cycle,
// directed scenarios with literal expectations, then biased random traffic.
module tb_hd44780_fifo;

    logic       clk = 1'b0;
    logic       rst_n, clear, push, pop;
    logic [7:0] din;
    logic [7:0] dout;
    logic       dout_valid, full, empty, almost_full, almost_empty;
    logic [4:0] count;
    logic       overflow, underflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq[$];
    bit         m_ovf, m_udf, m_valid;
    logic [7:0] m_dout;
    bit         started = 1'b0;

    always #5 clk = ~clk;

    hd44780_fifo #(
        .DATA_WIDTH   (8),
        .ADDR_WIDTH   (4),
        .AFULL_LEVEL  (12),
        .AEMPTY_LEVEL (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .push         (push),
        .din          (din),
        .pop          (pop),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one clock edge with the inputs currently applied.
    task automatic model_edge();
        bit m_full, m_empty;
        if (!rst_n) begin
            mq.delete();
            m_ovf = 0; m_udf = 0; m_valid = 0; m_dout = 8'h00;
        end else if (clear) begin
            mq.delete();
            m_ovf = 0; m_udf = 0; m_valid = 0;
        end else begin
            m_full  = (mq.size() == 16);
            m_empty = (mq.size() == 0);
            m_valid = 0;
            if (pop && !m_empty) begin
                m_dout  = mq.pop_front();
                m_valid = 1;
            end
            if (push && !m_full) mq.push_back(din);
            if (push && m_full)  m_ovf = 1;
            if (pop && m_empty)  m_udf = 1;
        end
    endtask

    // Compare process: DUT outputs against the model every cycle, mid-period.
    always @(negedge clk) begin
        if (started) begin
            chk("count",        32'(count),        32'(mq.size()));
            chk("full",         32'(full),         32'(mq.size() == 16));
            chk("empty",        32'(empty),        32'(mq.size() == 0));
            chk("almost_full",  32'(almost_full),  32'(mq.size() >= 12));
            chk("almost_empty", 32'(almost_empty), 32'(mq.size() <= 2));
            chk("overflow",     32'(overflow),     32'(m_ovf));
            chk("underflow",    32'(underflow),    32'(m_udf));
            chk("dout_valid",   32'(dout_valid),   32'(m_valid));
            chk("dout",         32'(dout),         32'(m_dout));
        end
    end

    task automatic step(input bit r, input bit c, input bit p, input bit o, input logic [7:0] d);
        rst_n = r; clear = c; push = p; pop = o; din = d;
        @(posedge clk);
        model_edge();
        started = 1'b1;
        #1;
    endtask

    int ppush, ppop;

    initial begin
        rst_n = 0; clear = 0; push = 0; pop = 0; din = 8'h00;
        step(0, 0, 0, 0, 8'h00);
        step(0, 0, 1, 1, 8'h5A);
        chk("lit_rst_empty", 32'(empty), 32'd1);
        chk("lit_rst_aempty", 32'(almost_empty), 32'd1);
        chk("lit_rst_full", 32'(full), 32'd0);
        chk("lit_rst_dout", 32'(dout), 32'd0);

        // Three pushes then three pops.
        step(1, 0, 1, 0, 8'h11);
        step(1, 0, 1, 0, 8'h22);
        step(1, 0, 1, 0, 8'h33);
        chk("lit_cnt3", 32'(count), 32'd3);
        chk("lit_nempty", 32'(empty), 32'd0);
        step(1, 0, 0, 1, 8'h00);
        chk("lit_pop1", 32'({dout_valid, dout}), 32'h111);
        step(1, 0, 0, 1, 8'h00);
        chk("lit_pop2", 32'({dout_valid, dout}), 32'h122);
        step(1, 0, 0, 1, 8'h00);
        chk("lit_pop3", 32'({dout_valid, dout}), 32'h133);
        step(1, 0, 0, 0, 8'h00);
        chk("lit_hold", 32'({dout_valid, dout}), 32'h033);

        // Fill to 16, then overflow.
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 1, 0, 8'(i));
            if (i == 10) chk("lit_af_11", 32'(almost_full), 32'd0);
            if (i == 11) chk("lit_af_12", 32'(almost_full), 32'd1);
        end
        chk("lit_full", 32'(full), 32'd1);
        step(1, 0, 1, 0, 8'hAA);
        chk("lit_ovf", 32'(overflow), 32'd1);
        chk("lit_cnt16", 32'(count), 32'd16);

        // Full with push and pop together: pop wins, push dropped.
        step(1, 0, 1, 1, 8'hBB);
        chk("lit_cnt15", 32'(count), 32'd15);
        chk("lit_pp_dout", 32'({dout_valid, dout}), 32'h100);
        while (mq.size() > 0) step(1, 0, 0, 1, 8'h00);

        // Underflow from empty, then push+pop on empty.
        step(0, 0, 0, 0, 8'h00);
        step(1, 0, 0, 1, 8'h00);
        chk("lit_udf", 32'(underflow), 32'd1);
        chk("lit_udf_nv", 32'(dout_valid), 32'd0);
        step(1, 0, 1, 1, 8'h77);
        chk("lit_pp_cnt1", 32'(count), 32'd1);
        chk("lit_pp_nv", 32'(dout_valid), 32'd0);

        // Half full, continuous push/pop across pointer wraps.
        while (mq.size() < 8) step(1, 0, 1, 0, 8'($urandom));
        for (int i = 0; i < 40; i++) step(1, 0, 1, 1, 8'($urandom));
        chk("lit_half_cnt", 32'(count), 32'd8);

        // count=5 with overflow, then clear with push.
        while (mq.size() < 16) step(1, 0, 1, 0, 8'($urandom));
        step(1, 0, 1, 0, 8'hEE);
        while (mq.size() > 5) step(1, 0, 0, 1, 8'h00);
        chk("lit_c5_ovf", 32'({overflow, count}), 32'h25);
        step(1, 1, 1, 0, 8'h99);
        chk("lit_clr", 32'({overflow, empty, count}), 32'h20);
        while (mq.size() < 16) step(1, 0, 1, 0, 8'($urandom));
        step(1, 0, 1, 0, 8'hEE);
        while (mq.size() > 5) step(1, 0, 0, 1, 8'h00);
        step(0, 1, 1, 1, 8'h99);
        chk("lit_rst5", 32'({overflow, empty, count}), 32'h20);

        // Biased random traffic with occasional clear and reset.
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) begin
                ppush = $urandom_range(10, 90);
                ppop  = $urandom_range(10, 90);
            end
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 99) < ppush),
                 ($urandom_range(0, 99) < ppop),
                 8'($urandom));
        end
        step(1, 0, 0, 0, 8'h00);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
